// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative multiply/divide with HI/LO registers.
// One shift-add or restoring shift-subtract step per clock.
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             mthi,
  input  logic             mtlo,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             is_div;
  logic             neg_q;
  logic             neg_r;
  logic             dz;
  logic [WIDTH-1:0] dvsr;
  logic [WIDTH:0]   acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             done_q;
  logic             dz_q;

  logic             sgn;
  logic [WIDTH-1:0] a_abs;
  logic [WIDTH-1:0] b_abs;
  logic [WIDTH:0]   nxt_hi;
  logic [WIDTH-1:0] nxt_lo;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] diff;
  logic [WIDTH:0]   sum;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;
  logic             last;

  assign busy     = (state == RUN);
  assign done     = done_q;
  assign div_zero = dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

  // operand magnitudes for the signed ops
  always_comb begin
    sgn   = ~op[0];
    a_abs = (sgn && a[WIDTH-1]) ? -a : a;
    b_abs = (sgn && b[WIDTH-1]) ? -b : b;
  end

  // one iteration step plus sign-corrected results for commit
  always_comb begin
    rem_sh = {acc_hi[WIDTH-1:0], acc_lo[WIDTH-1]};
    diff   = {1'b0, rem_sh} - {2'b00, dvsr};
    sum    = {1'b0, acc_hi[WIDTH-1:0]}
           + (acc_lo[0] ? {1'b0, dvsr} : '0);
    nxt_hi = '0;
    nxt_lo = '0;
    if (is_div) begin
      if (!diff[WIDTH+1]) begin
        nxt_hi = diff[WIDTH:0];
        nxt_lo = {acc_lo[WIDTH-2:0], 1'b1};
      end else begin
        nxt_hi = rem_sh;
        nxt_lo = {acc_lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      nxt_hi = {1'b0, sum[WIDTH:1]};
      nxt_lo = {sum[0], acc_lo[WIDTH-1:1]};
    end
    prod     = {nxt_hi[WIDTH-1:0], nxt_lo};
    prod_fix = neg_q ? -prod : prod;
    q_fix    = dz ? '1 : (neg_q ? -nxt_lo : nxt_lo);
    r_fix    = neg_r ? -nxt_hi[WIDTH-1:0]
                     : nxt_hi[WIDTH-1:0];
    last     = (cnt == CNT_W'(WIDTH-1));
  end

  // control FSM, datapath registers and HI/LO
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      cnt    <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      dz     <= 1'b0;
      dvsr   <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
      dz_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dz_q   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state  <= RUN;
            cnt    <= '0;
            is_div <= op[1];
            neg_q  <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r  <= sgn & op[1] & a[WIDTH-1];
            dz     <= op[1] & (b == '0);
            dvsr   <= b_abs;
            acc_hi <= '0;
            acc_lo <= a_abs;
          end else begin
            if (mthi) hi_q <= a;
            if (mtlo) lo_q <= a;
          end
        end
        RUN: begin
          acc_hi <= nxt_hi;
          acc_lo <= nxt_lo;
          cnt    <= cnt + 1'b1;
          if (last) begin
            state  <= IDLE;
            cnt    <= '0;
            done_q <= 1'b1;
            dz_q   <= dz;
            if (is_div) begin
              hi_q <= r_fix;
              lo_q <= q_fix;
            end else begin
              {hi_q, lo_q} <= prod_fix;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed + random checks of mult_div_unit
// against a scoreboard of reference-model results.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        mthi;
  logic        mtlo;
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
  } exp_t;

  exp_t sb[$];

  mult_div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .a(a), .b(b), .mthi(mthi), .mtlo(mtlo),
    .busy(busy), .done(done), .div_zero(div_zero),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [1:0] o,
                                 input logic [31:0] x,
                                 input logic [31:0] y);
    exp_t e;
    logic signed [63:0] sx;
    logic signed [63:0] sy;
    logic signed [63:0] sq;
    logic signed [63:0] sr;
    logic [63:0] p;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    e.dz = 1'b0;
    e.hi = '0;
    e.lo = '0;
    case (o)
      2'b00: begin
        p = sx * sy;
        e.hi = p[63:32];
        e.lo = p[31:0];
      end
      2'b01: begin
        p = {32'b0, x} * {32'b0, y};
        e.hi = p[63:32];
        e.lo = p[31:0];
      end
      default: begin
        if (y == 32'd0) begin
          e.dz = 1'b1;
          e.lo = 32'hFFFF_FFFF;
          e.hi = x;
        end else if (o == 2'b10) begin
          sq = sx / sy;
          sr = sx % sy;
          e.lo = sq[31:0];
          e.hi = sr[31:0];
        end else begin
          e.lo = x / y;
          e.hi = x % y;
        end
      end
    endcase
    return e;
  endfunction

  // launch op, wait for done (bounded), compare against scoreboard
  task automatic run_op(input string tag,
                        input logic [1:0] o,
                        input logic [31:0] x,
                        input logic [31:0] y,
                        input logic [31:0] eh,
                        input logic [31:0] el,
                        input logic ed,
                        input bit disturb);
    exp_t e;
    int cyc;
    int busy_n;
    @(negedge clk);
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    e.hi = eh;
    e.lo = el;
    e.dz = ed;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    cyc = 1;
    busy_n = 0;
    while (!done && cyc < 40) begin
      if (busy) busy_n++;
      if (disturb && cyc == 5) begin
        start = 1'b1;
        op = 2'b11;
        mthi = 1'b1;
        a = 32'h0000_DEAD;
      end
      if (disturb && cyc == 6) begin
        start = 1'b0;
        mthi = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_busy_cycles"}, 64'(busy_n), 64'd32);
    e = sb.pop_front();
    check({tag, "_hi"}, 64'(hi), 64'(e.hi));
    check({tag, "_lo"}, 64'(lo), 64'(e.lo));
    check({tag, "_dz"}, 64'(div_zero), 64'(e.dz));
    @(negedge clk);
    check({tag, "_done_after"}, 64'(done), 64'd0);
    check({tag, "_dz_after"}, 64'(div_zero), 64'd0);
    check({tag, "_idle_after"}, 64'(busy), 64'd0);
  endtask

  initial begin
    exp_t m;
    logic [1:0]  ro;
    logic [31:0] ra;
    logic [31:0] rb;
    rst = 1'b0;
    start = 1'b0;
    op = 2'b00;
    a = '0;
    b = '0;
    mthi = 1'b0;
    mtlo = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_dz", 64'(div_zero), 64'd0);
    rst = 1'b1;

    run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           32'hFFFF_FFFE, 32'h0000_0001, 1'b0, 1'b0);
    run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'd7,
           32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, 1'b0);
    run_op("divu_100_7", 2'b11, 32'd100, 32'd7,
           32'd2, 32'd14, 1'b0, 1'b0);
    run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'd2,
           32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, 1'b0);
    run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF,
           32'd0, 32'h8000_0000, 1'b0, 1'b0);
    run_op("divu_zero", 2'b11, 32'h0000_1234, 32'd0,
           32'h0000_1234, 32'hFFFF_FFFF, 1'b1, 1'b0);
    run_op("div_zero_neg", 2'b10, 32'hFFFF_FF00, 32'd0,
           32'hFFFF_FF00, 32'hFFFF_FFFF, 1'b1, 1'b0);
    run_op("multu_disturb", 2'b01, 32'd5, 32'd6,
           32'd0, 32'd30, 1'b0, 1'b1);

    @(negedge clk);
    mthi = 1'b1;
    a = 32'h0000_DEAD;
    @(negedge clk);
    mthi = 1'b0;
    check("mthi_idle_hi", 64'(hi), 64'h0000_DEAD);
    check("mthi_idle_lo", 64'(lo), 64'd30);
    mthi = 1'b1;
    mtlo = 1'b1;
    a = 32'h5555_AAAA;
    @(negedge clk);
    mthi = 1'b0;
    mtlo = 1'b0;
    check("mtboth_hi", 64'(hi), 64'h5555_AAAA);
    check("mtboth_lo", 64'(lo), 64'h5555_AAAA);

    start = 1'b1;
    mthi = 1'b1;
    op = 2'b00;
    a = 32'd5;
    b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    mthi = 1'b0;
    check("start_wins_hi", 64'(hi), 64'h5555_AAAA);
    check("start_busy", 64'(busy), 64'd1);
    repeat (9) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_hi", 64'(hi), 64'd0);
    check("arst_lo", 64'(lo), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    run_op("multu_after_rst", 2'b01, 32'd2, 32'd3,
           32'd0, 32'd6, 1'b0, 1'b0);

    for (int i = 0; i < 8; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = (i == 3) ? 32'd0 : $urandom;
      if (i[0]) rb = rb >> $urandom_range(0, 31);
      m = model(ro, ra, rb);
      run_op($sformatf("rand%0d_op%0d", i, ro), ro, ra, rb,
             m.hi, m.lo, m.dz, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
